// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller with a Nios II custom-instruction port.
// Define DISPLAY_SCAN_DP_EN to add a per-digit decimal point and the dp output.
package display_scan_pkg;
  typedef struct packed {
    logic       dp;
    logic       blank;
    logic [3:0] val;
  } cell_t;

  typedef enum logic {SHOW, BLANK} state_t;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction
endpackage

// One digit's storage; comes out of reset blank.
module display_scan_digit
  import display_scan_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  we_i,
  input  cell_t wdata_i,
  output cell_t q_o
);
  cell_t q_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q_q <= '{dp: 1'b0, blank: 1'b1, val: 4'd0};
    else if (we_i) q_q <= wdata_i;
  end

  assign q_o = q_q;
endmodule

module display_scan_ctrl
  import display_scan_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        n,
  input  logic [31:0]       dataa,
  input  logic [31:0]       datab,
  output logic              done,
  output logic [31:0]       result,
  output logic [6:0]        display,
  output logic [DIGITS-1:0] digit_sel
`ifdef DISPLAY_SCAN_DP_EN
  ,
  output logic              dp
`endif
);
  localparam int IW   = $clog2(DIGITS);
  localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  cell_t [DIGITS-1:0] cells;
  logic  [DIGITS-1:0] we;
  logic  [DIGITS-1:0] mask_q;
  cell_t              wcell, rd_cell;
  logic  [2:0]        addr;
  logic  [31:0]       res_d, result_q;
  logic               done_q;
  logic               unused_ok;

  assign addr      = dataa[2:0];
  assign unused_ok = ^{dataa, datab};

  always_comb begin
    wcell.val   = datab[3:0];
    wcell.blank = datab[4];
`ifdef DISPLAY_SCAN_DP_EN
    wcell.dp    = datab[5];
`else
    wcell.dp    = 1'b0;
`endif
  end

  // Addresses past the last digit match no cell: writes drop, reads return 0.
  always_comb begin
    we      = '0;
    rd_cell = '0;
    for (int i = 0; i < DIGITS; i++) begin
      we[i] = start && (n == 2'd0) && (addr == 3'(i));
      if (addr == 3'(i)) rd_cell = cells[i];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    display_scan_digit u_dig (
      .clk     (clk),
      .reset_n (reset_n),
      .we_i    (we[g]),
      .wdata_i (wcell),
      .q_o     (cells[g])
    );
  end

  always_comb begin
    res_d = '0;
    case (n)
      2'd0, 2'd1: res_d = {26'd0, rd_cell};
      2'd2:       res_d = 32'(mask_q);
      default:    res_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q   <= 1'b0;
      result_q <= '0;
      mask_q   <= '1;
    end else begin
      done_q   <= start;
      result_q <= start ? res_d : '0;
      if (start && n == 2'd2) mask_q <= datab[DIGITS-1:0];
    end
  end

  state_t            state_q;
  logic [IW-1:0]     idx_q, idx_nxt;
  logic [CW-1:0]     cnt_q;
  logic [6:0]        display_q;
  logic [DIGITS-1:0] sel_q;
`ifdef DISPLAY_SCAN_DP_EN
  logic              dp_q;
`endif

  assign idx_nxt = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);

  // Outputs are registered from the current state, so they trail the
  // state by one cycle and storage writes show up the cycle after done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= SHOW;
      idx_q     <= '0;
      cnt_q     <= '0;
      display_q <= '0;
      sel_q     <= '0;
`ifdef DISPLAY_SCAN_DP_EN
      dp_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        SHOW: begin
          sel_q     <= mask_q & (DIGITS'(1) << idx_q);
          display_q <= (cells[idx_q].blank || !mask_q[idx_q]) ? 7'd0
                                                              : hex7(cells[idx_q].val);
`ifdef DISPLAY_SCAN_DP_EN
          dp_q      <= mask_q[idx_q] & cells[idx_q].dp;
`endif
          if (cnt_q == CW'(REFRESH_DIV - 1)) begin
            cnt_q <= '0;
            if (BLANK_CYCLES == 0) idx_q <= idx_nxt;
            else state_q <= BLANK;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          sel_q     <= '0;
          display_q <= '0;
`ifdef DISPLAY_SCAN_DP_EN
          dp_q      <= 1'b0;
`endif
          if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
            cnt_q   <= '0;
            idx_q   <= idx_nxt;
            state_q <= SHOW;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  assign done      = done_q;
  assign result    = result_q;
  assign display   = display_q;
  assign digit_sel = sel_q;
`ifdef DISPLAY_SCAN_DP_EN
  assign dp        = dp_q;
`endif
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: command table, hand sequences,
// and random traffic against a slot-arithmetic reference model.
module tb_display_scan_ctrl;
  localparam int DIGITS = 4;
  localparam int RD     = 4;
  localparam int BC     = 1;
  localparam int PER    = RD + BC;
  localparam int FRAME  = DIGITS * PER;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        n = '0;
  logic [31:0]       dataa = '0, datab = '0;
  logic              done;
  logic [31:0]       result;
  logic [6:0]        display;
  logic [DIGITS-1:0] digit_sel;
`ifdef DISPLAY_SCAN_DP_EN
  logic              dp;
`endif

  display_scan_ctrl #(.DIGITS(DIGITS), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .n         (n),
    .dataa     (dataa),
    .datab     (datab),
    .done      (done),
    .result    (result),
    .display   (display),
    .digit_sel (digit_sel)
`ifdef DISPLAY_SCAN_DP_EN
    ,
    .dp        (dp)
`endif
  );

  always #5 clk = ~clk;

  logic [6:0] seg [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  int checks = 0;
  int failures = 0;

  int         k;
  logic [3:0] m_val [DIGITS];
  logic       m_blank [DIGITS];
  logic [3:0] m_mask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d actual=0x%0h required=0x%0h", name, k, act, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < DIGITS; i++) begin
      m_val[i]   = 4'd0;
      m_blank[i] = 1'b1;
    end
    m_mask = 4'hF;
  endtask

  // One clock: expected outputs come from the model as it stood before the edge.
  task automatic step(input logic st, input logic [1:0] nn,
                      input logic [31:0] a, input logic [31:0] b);
    int p, d, ii;
    logic [3:0]  esel;
    logic [6:0]  edisp;
    logic [31:0] eres;
    start = st; n = nn; dataa = a; datab = b;
    k++;
    p = (k - 1) % FRAME;
    d = p / PER;
    esel = '0; edisp = '0;
    if ((p % PER) < RD && m_mask[d]) begin
      esel[d] = 1'b1;
      if (!m_blank[d]) edisp = seg[m_val[d]];
    end
    ii = int'(a[2:0]);
    eres = '0;
    if (st) begin
      case (nn)
        2'd0: if (ii < DIGITS) begin
          eres = {27'd0, m_blank[ii], m_val[ii]};
          m_blank[ii] = b[4];
          m_val[ii]   = b[3:0];
        end
        2'd1: if (ii < DIGITS) eres = {27'd0, m_blank[ii], m_val[ii]};
        2'd2: begin
          eres   = {28'd0, m_mask};
          m_mask = b[3:0];
        end
        default: eres = '0;
      endcase
    end
    @(posedge clk); #1;
    chk("done", {31'd0, done}, {31'd0, st});
    if (st) chk("result", result, eres);
    chk("digit_sel", {28'd0, digit_sel}, {28'd0, esel});
    chk("display", {25'd0, display}, {25'd0, edisp});
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 2'd0, 32'd0, 32'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_done"},   {31'd0, done}, 32'd0);
    chk({tag, "_result"}, result, 32'd0);
    chk({tag, "_disp"},   {25'd0, display}, 32'd0);
    chk({tag, "_sel"},    {28'd0, digit_sel}, 32'd0);
  endtask

  typedef struct {
    logic [1:0]  n;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{2'd0, 32'd2, 32'h05, 32'h10};
    tbl[1]  = '{2'd1, 32'd2, 32'h00, 32'h05};
    tbl[2]  = '{2'd1, 32'd6, 32'h00, 32'h00};
    tbl[3]  = '{2'd2, 32'd0, 32'h0B, 32'h0F};
    tbl[4]  = '{2'd1, 32'd0, 32'h00, 32'h10};
    tbl[5]  = '{2'd3, 32'd2, 32'h1F, 32'h00};
    tbl[6]  = '{2'd0, 32'd6, 32'h03, 32'h00};
    tbl[7]  = '{2'd1, 32'd6, 32'h00, 32'h00};
    tbl[8]  = '{2'd0, 32'd2, 32'h1F, 32'h05};
    tbl[9]  = '{2'd1, 32'd2, 32'h00, 32'h1F};
    tbl[10] = '{2'd2, 32'd0, 32'h0F, 32'h0B};
    tbl[11] = '{2'd1, 32'd1, 32'h00, 32'h08};

    model_reset();
    #23;
    chk_zero_outputs("reset_hold");
    @(negedge clk);
    reset_n = 1'b1;

    // Scan order after reset, then a mid-slot write to digit 1.
    step(1'b0, 2'd0, 32'd0, 32'd0);
    chk("first_sel", {28'd0, digit_sel}, 32'h1);
    chk("first_disp", {25'd0, display}, 32'h0);
    idle(3);
    step(1'b0, 2'd0, 32'd0, 32'd0);
    chk("k5_blank_sel", {28'd0, digit_sel}, 32'h0);
    step(1'b0, 2'd0, 32'd0, 32'd0);
    chk("k6_sel", {28'd0, digit_sel}, 32'h2);
    step(1'b0, 2'd0, 32'd0, 32'd0);
    step(1'b1, 2'd0, 32'd1, 32'h08);
    chk("mid_wr_result", result, 32'h10);
    chk("mid_wr_disp_old", {25'd0, display}, 32'h0);
    step(1'b0, 2'd0, 32'd0, 32'd0);
    chk("mid_wr_disp_new", {25'd0, display}, 32'h7F);
    chk("mid_wr_sel", {28'd0, digit_sel}, 32'h2);
    step(1'b0, 2'd0, 32'd0, 32'd0);
    chk("slot_end_sel", {28'd0, digit_sel}, 32'h0);
    step(1'b0, 2'd0, 32'd0, 32'd0);
    chk("next_slot_sel", {28'd0, digit_sel}, 32'h4);

    for (int i = 0; i < 12; i++) begin
      step(1'b1, tbl[i].n, tbl[i].a, tbl[i].b);
      chk($sformatf("tbl%0d_result", i), result, tbl[i].res);
    end
    step(1'b1, 2'd2, 32'd0, 32'h0B);
    idle(2 * FRAME);
    step(1'b1, 2'd2, 32'd0, 32'h0F);
    idle(FRAME);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);

    // Reset during digit 3 SHOW with a command in flight.
    while (((k % FRAME) / PER) != 3 || (k % FRAME) % PER > 1) idle(1);
    step(1'b1, 2'd1, 32'd0, 32'd0);
    start = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_zero_outputs("async_rst");
    @(posedge clk); #1;
    chk_zero_outputs("rst_held");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    step(1'b0, 2'd0, 32'd0, 32'd0);
    chk("rerun_sel", {28'd0, digit_sel}, 32'h1);
    idle(FRAME);
    step(1'b1, 2'd1, 32'd2, 32'd0);
    chk("rerun_blank_rd", result, 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
